// File: rtl/lsu_pkg.sv
// Shared types for the Wishbone load/store unit: access sizes, completion causes, FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        CAUSE_OK         = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_BUS_ERR    = 2'd2,
        CAUSE_TIMEOUT    = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_BACKOFF,
        ST_RESP
    } state_e;

    // Byte-enable pattern of an access before it is shifted into its lane.
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_byte_mask = 8'h01;
            SIZE_HALF: size_byte_mask = 8'h03;
            SIZE_WORD: size_byte_mask = 8'h0F;
            default:   size_byte_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: byte enables, store data placement,
// load extraction with sign/zero extension, and misalignment detection.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]                      size_i,
    input  logic                            unsigned_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] off_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic [DATA_WIDTH-1:0]           rdata_raw_i,
    output logic [DATA_WIDTH/8-1:0]         sel_o,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            misaligned_o
);

    localparam int SEL_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] rd_shifted;
    logic [DATA_WIDTH-1:0] rd_left;
    logic [6:0]            ext_shamt;

    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_BYTE: misaligned_o = 1'b0;
            SIZE_HALF: misaligned_o = off_i[0];
            SIZE_WORD: misaligned_o = |off_i[1:0];
            default:   misaligned_o = (DATA_WIDTH == 32) || (|off_i);
        endcase
    end

    assign sel_o   = SEL_W'({8'h00, size_byte_mask(size_i)} << off_i);
    assign wdata_o = wdata_i << {off_i, 3'b000};

    // Park the access in the top bits, then shift back down so the fill comes
    // from the arithmetic/logical shift rather than a per-size replication.
    always_comb begin
        ext_shamt = '0;
        case (size_i)
            SIZE_BYTE: ext_shamt = 7'(DATA_WIDTH - 8);
            SIZE_HALF: ext_shamt = 7'(DATA_WIDTH - 16);
            SIZE_WORD: ext_shamt = 7'(DATA_WIDTH - 32);
            default:   ext_shamt = '0;
        endcase
        rd_shifted = rdata_raw_i >> {off_i, 3'b000};
        rd_left    = rd_shifted << ext_shamt;
        if (unsigned_i) begin
            rdata_o = rd_left >> ext_shamt;
        end else begin
            rdata_o = DATA_WIDTH'($signed(rd_left) >>> ext_shamt);
        end
    end

endmodule

// File: rtl/wb_load_store_unit.sv
// Wishbone classic master executing one load/store per request, with err/rty handling.
// Optional bus watchdog enabled by defining LSU_BUS_TIMEOUT_EN.
module wb_load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]              rsp_cause_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    ack_i,
    input  logic                    err_i,
    input  logic                    rty_i,
    output logic                    stb_o,
    output logic                    cyc_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH/8-1:0] sel_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(SEL_W);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_load_store_unit: DATA_WIDTH must be 32 or 64 and TIMEOUT_CYCLES >= 1");
    end

    state_e                  state_q, state_d;
    logic [RTY_W-1:0]        retry_q, retry_d;
    logic                    we_q, uns_q;
    logic [1:0]              size_q;
    logic [OFF_W-1:0]        off_q;

    logic                    ready_q, rsp_valid_q, cyc_q, bus_we_q;
    cause_e                  cause_q, cause_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, dat_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [SEL_W-1:0]        sel_q;

    logic                    accept, bus_load;
    logic [1:0]              al_size;
    logic                    al_uns, al_mis;
    logic [OFF_W-1:0]        al_off;
    logic [SEL_W-1:0]        al_sel;
    logic [DATA_WIDTH-1:0]   al_wdata, al_rdata;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]         wdog_q, wdog_d;
`endif

    assign accept = req_valid_i & ready_q;

    // One aligner serves both phases: live request fields in IDLE, latched ones afterwards.
    assign al_size = (state_q == ST_IDLE) ? req_size_i               : size_q;
    assign al_uns  = (state_q == ST_IDLE) ? req_unsigned_i           : uns_q;
    assign al_off  = (state_q == ST_IDLE) ? req_addr_i[OFF_W-1:0]    : off_q;

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size_i       (al_size),
        .unsigned_i   (al_uns),
        .off_i        (al_off),
        .wdata_i      (req_wdata_i),
        .rdata_raw_i  (dat_i),
        .sel_o        (al_sel),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_mis)
    );

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        cause_d  = CAUSE_OK;
        rdata_d  = '0;
        bus_load = 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
        wdog_d   = wdog_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    retry_d = '0;
`ifdef LSU_BUS_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                    if (al_mis) begin
                        state_d = ST_RESP;
                        cause_d = CAUSE_MISALIGNED;
                    end else begin
                        state_d  = ST_BUS;
                        bus_load = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (err_i) begin
                    state_d = ST_RESP;
                    cause_d = CAUSE_BUS_ERR;
                end else if (ack_i) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        rdata_d = al_rdata;
                    end
                end else if (rty_i) begin
                    if (retry_q == RTY_W'(MAX_RETRY)) begin
                        state_d = ST_RESP;
                        cause_d = CAUSE_BUS_ERR;
                    end else begin
                        state_d = ST_BACKOFF;
                        retry_d = retry_q + 1'b1;
                    end
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_RESP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            ST_BACKOFF: begin
                state_d = ST_BUS;
`ifdef LSU_BUS_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            retry_q     <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            cause_q     <= CAUSE_OK;
            rdata_q     <= '0;
            cyc_q       <= 1'b0;
            bus_we_q    <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            cause_q     <= cause_d;
            rdata_q     <= rdata_d;
            cyc_q       <= (state_d == ST_BUS);
            if (accept) begin
                we_q   <= req_we_i;
                uns_q  <= req_unsigned_i;
                size_q <= req_size_i;
                off_q  <= req_addr_i[OFF_W-1:0];
            end
            // Bus fields are held through BACKOFF so a re-issue is identical.
            if (bus_load) begin
                adr_q    <= {req_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                sel_q    <= al_sel;
                dat_q    <= al_wdata;
                bus_we_q <= req_we_i;
            end else if (state_d == ST_RESP || state_d == ST_IDLE) begin
                adr_q    <= '0;
                sel_q    <= '0;
                dat_q    <= '0;
                bus_we_q <= 1'b0;
            end
        end
    end

`ifdef LSU_BUS_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_cause_o = cause_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;
    assign we_o        = bus_we_q;
    assign adr_o       = adr_q;
    assign sel_o       = sel_q;
    assign dat_o       = dat_q;

endmodule

// File: tb/tb_wb_load_store_unit.sv
// Self-checking bench for wb_load_store_unit: 32-bit instance with a reference model and
// randomized slave behaviour, plus a 64-bit instance exercised with directed accesses.
module tb_wb_load_store_unit;

    localparam int MAXR = 3;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, req_uns, rsp_valid;
    logic        ack, err, rty, stb, cyc, we_o;
    logic [1:0]  req_size, rsp_cause;
    logic [31:0] req_addr, req_wdata, rsp_rdata, s_dat, m_dat, adr;
    logic [3:0]  sel;

    logic        req_valid_w, req_ready_w, req_we_w, req_uns_w, rsp_valid_w;
    logic        ack_w, err_w, rty_w, stb_w, cyc_w, we_o_w;
    logic [1:0]  req_size_w, rsp_cause_w;
    logic [31:0] req_addr_w, adr_w;
    logic [63:0] req_wdata_w, rsp_rdata_w, s_dat_w, m_dat_w;
    logic [7:0]  sel_w;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_load_store_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TO)
    ) dut32 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_cause_o(rsp_cause), .dat_i(s_dat), .dat_o(m_dat), .ack_i(ack), .err_i(err),
        .rty_i(rty), .stb_o(stb), .cyc_o(cyc), .we_o(we_o), .adr_o(adr), .sel_o(sel)
    );

    wb_load_store_unit #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TO)
    ) dut64 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_w), .req_ready_o(req_ready_w), .req_we_i(req_we_w),
        .req_size_i(req_size_w), .req_unsigned_i(req_uns_w), .req_addr_i(req_addr_w),
        .req_wdata_i(req_wdata_w), .rsp_valid_o(rsp_valid_w), .rsp_rdata_o(rsp_rdata_w),
        .rsp_cause_o(rsp_cause_w), .dat_i(s_dat_w), .dat_o(m_dat_w), .ack_i(ack_w), .err_i(err_w),
        .rty_i(rty_w), .stb_o(stb_w), .cyc_o(cyc_w), .we_o(we_o_w), .adr_o(adr_w), .sel_o(sel_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // term: 0 ack, 1 err, 2 err+ack, 3 ack+rty on the final issue; waits < 0 means never reply.
    task automatic run32(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] sdata,
                         input int waits, input int n_rty, input int term);
        logic            mis;
        int              off, nb, issues, exp_lat, exp_stb, c, wcnt, idx, stb_cycles;
        logic [1:0]      exp_cause;
        longint unsigned mask, v;
        logic [31:0]     exp_rdata, exp_adr, exp_dat;
        logic [3:0]      exp_sel;

        nb      = 1 << size;
        off     = int'(addr % 4);
        mis     = (size == 2'd3) || (addr % nb != 0);
        exp_adr = addr - 32'(off);
        exp_sel = 4'(((1 << nb) - 1) << off);
        exp_dat = 32'(64'(wdata) << (8 * off));
        if (mis)              issues = 0;
        else if (waits < 0)   issues = 1;
        else if (n_rty > MAXR) issues = MAXR + 1;
        else                  issues = n_rty + 1;
        if (mis)                        exp_cause = 2'd1;
        else if (waits < 0)             exp_cause = 2'd3;
        else if (n_rty > MAXR)          exp_cause = 2'd2;
        else if (term == 1 || term == 2) exp_cause = 2'd2;
        else                            exp_cause = 2'd0;
        exp_rdata = '0;
        if (exp_cause == 2'd0 && !we) begin
            mask = (64'd1 << (8 * nb)) - 1;
            v    = (64'(sdata) >> (8 * off)) & mask;
            if (!uns && v[8*nb-1]) v = v | ~mask;
            exp_rdata = v[31:0];
        end
        exp_lat = mis ? 1 : (waits < 0) ? TO + 1 : issues * (waits + 2);
        exp_stb = mis ? 0 : (waits < 0) ? TO : issues * (waits + 1);

        c = 0;
        while (!req_ready && c < 20) begin @(negedge clk); c++; end
        check("ready_before_req", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_uns = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        c = 1; wcnt = 0; idx = 1; stb_cycles = 0;
        while (!rsp_valid && c <= 60) begin
            ack = 1'b0; err = 1'b0; rty = 1'b0; s_dat = $urandom;
            if (stb) begin
                stb_cycles++;
                if (wcnt == 0) begin
                    check("adr", 64'(adr), 64'(exp_adr));
                    check("sel", 64'(sel), 64'(exp_sel));
                    check("we_o", 64'(we_o), 64'(we));
                    check("cyc", 64'(cyc), 64'(1));
                    if (we) check("dat_o", 64'(m_dat), 64'(exp_dat));
                end
                if (waits >= 0 && wcnt == waits) begin
                    s_dat = sdata;
                    if (idx <= n_rty) begin
                        rty = 1'b1; idx++; wcnt = 0;
                    end else begin
                        case (term)
                            0:       ack = 1'b1;
                            1:       err = 1'b1;
                            2:       begin err = 1'b1; ack = 1'b1; end
                            default: begin ack = 1'b1; rty = 1'b1; end
                        endcase
                        wcnt++;
                    end
                end else begin
                    wcnt++;
                end
            end else if ($urandom_range(3) == 0) begin
                ack = 1'b1; err = 1'($urandom); rty = 1'($urandom);
            end
            @(negedge clk);
            c++;
        end
        ack = 1'b0; err = 1'b0; rty = 1'b0;
        check("rsp_latency", 64'(c), 64'(exp_lat));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        check("rsp_cause", 64'(rsp_cause), 64'(exp_cause));
        check("stb_cycles", 64'(stb_cycles), 64'(exp_stb));
        @(negedge clk);
        check("rsp_one_cycle", 64'(rsp_valid), 64'(0));
        check("ready_after_rsp", 64'(req_ready), 64'(1));
    endtask

    task automatic run64(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] sdata,
                         input logic [31:0] e_adr, input logic [7:0] e_sel, input logic [63:0] e_dat,
                         input logic [63:0] e_rdata, input logic [1:0] e_cause);
        int c, nstb;
        c = 0;
        while (!req_ready_w && c < 20) begin @(negedge clk); c++; end
        check("w_ready_before_req", 64'(req_ready_w), 64'(1));
        req_valid_w = 1'b1; req_we_w = we; req_size_w = size; req_uns_w = uns;
        req_addr_w = addr; req_wdata_w = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid_w = 1'b0;
        c = 1; nstb = 0;
        while (!rsp_valid_w && c <= 20) begin
            ack_w = 1'b0; s_dat_w = sdata;
            if (stb_w) begin
                nstb++;
                check("w_adr", 64'(adr_w), 64'(e_adr));
                check("w_sel", 64'(sel_w), 64'(e_sel));
                check("w_we_o", 64'(we_o_w), 64'(we));
                if (we) check("w_dat_o", m_dat_w, e_dat);
                ack_w = 1'b1;
            end
            @(negedge clk);
            c++;
        end
        ack_w = 1'b0;
        check("w_rsp_latency", 64'(c), (e_cause == 2'd1) ? 64'(1) : 64'(2));
        check("w_stb_cycles", 64'(nstb), (e_cause == 2'd1) ? 64'(0) : 64'(1));
        check("w_rsp_rdata", rsp_rdata_w, e_rdata);
        check("w_rsp_cause", 64'(rsp_cause_w), 64'(e_cause));
        @(negedge clk);
    endtask

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : main
        logic [1:0]  rs;
        logic [31:0] ra;
        logic        seen;
        int          c;

        req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_uns = 1'b0;
        req_addr = '0; req_wdata = '0; s_dat = '0; ack = 1'b0; err = 1'b0; rty = 1'b0;
        req_valid_w = 1'b0; req_we_w = 1'b0; req_size_w = '0; req_uns_w = 1'b0;
        req_addr_w = '0; req_wdata_w = '0; s_dat_w = '0; ack_w = 1'b0; err_w = 1'b0; rty_w = 1'b0;

        #1 rst = 1'b1;
        #2;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_cause", 64'(rsp_cause), 64'(0));
        check("rst_cyc_stb", 64'({cyc, stb, we_o}), 64'(0));
        check("rst_adr_sel", 64'({adr, sel}), 64'(0));
        check("rst_dat_o", 64'(m_dat), 64'(0));
        check("rst_w_ready", 64'(req_ready_w), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready), 64'(1));

        // Directed accesses from the test plan, 32-bit path.
        run32(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 2, 0, 0);
        run32(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80000000, 0, 0, 0);
        run32(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80000000, 0, 0, 0);
        run32(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h12345678, 0, 0, 0);
        run32(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h11111111, 0, 4, 0);
        run32(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h22223333, 0, 2, 0);
        run32(1'b1, 2'd1, 1'b0, 32'h22, 32'hBEEF1234, 32'h0, 1, 0, 1);
        run32(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 32'h8765ABCD, 0, 0, 2);
        run32(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 32'h8765ABCD, 1, 1, 3);
        run32(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h0, 0, 0, 0);

        // Reset in the middle of a bus cycle.
        c = 0;
        while (!req_ready && c < 20) begin @(negedge clk); c++; end
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h400;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stb_before_reset", 64'(stb), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("cyc_on_reset", 64'(cyc), 64'(0));
        check("stb_on_reset", 64'(stb), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_reset", 64'(seen), 64'(0));
        check("ready_after_mid_reset", 64'(req_ready), 64'(1));

`ifdef LSU_BUS_TIMEOUT_EN
        run32(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h5, -1, 0, 0);
        run32(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'hCAFEF00D, TO - 1, 0, 0);
        run32(1'b1, 2'd0, 1'b0, 32'h305, 32'hA5, 32'h0, -1, 0, 0);
`endif

        // 64-bit path.
        run64(1'b1, 2'd1, 1'b0, 32'h16, 64'hABCD, 64'h0,
              32'h10, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 2'd0);
        run64(1'b0, 2'd3, 1'b0, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF,
              32'h8, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 2'd0);
        run64(1'b0, 2'd2, 1'b0, 32'h4, 64'h0, 64'h8000_0000_0000_0000,
              32'h0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000, 2'd0);
        run64(1'b0, 2'd0, 1'b1, 32'h7, 64'h0, 64'hFE00_0000_0000_0000,
              32'h0, 8'h80, 64'h0, 64'h0000_0000_0000_00FE, 2'd0);
        run64(1'b0, 2'd1, 1'b0, 32'h2, 64'h0, 64'h0000_0000_8001_0000,
              32'h0, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 2'd0);
        run64(1'b0, 2'd3, 1'b0, 32'h4, 64'h0, 64'h0,
              32'h0, 8'h00, 64'h0, 64'h0, 2'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            rs = 2'($urandom_range(3));
            ra = $urandom;
            if ($urandom_range(3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
            run32(1'($urandom), rs, 1'($urandom), ra, $urandom, $urandom,
                  int'($urandom_range(3)),
                  ($urandom_range(3) == 0) ? int'($urandom_range(4)) : 0,
                  int'($urandom_range(3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_load_store_unit.md
# wb_load_store_unit

Parametrised Wishbone classic bus master that executes one load or store per request for the multi-cycle core. It handles byte-lane steering, sign/zero extension, misalignment detection, error and retry termination, and an optional bus watchdog. It generalises the core's inline memory-state logic to 32- or 64-bit data paths and adds the `err_i`/`rty_i` handling the core does not have. It sits between the core's memory stage and the system bus.

## Interface
- `DATA_WIDTH`, 32: bus and register data width; legal values are 32 and 64.
- `ADDR_WIDTH`, 32: byte address width.
- `MAX_RETRY`, 3: number of re-issues allowed after `rty_i`; 0 means the first `rty_i` is fatal.
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles; used only with the macro.

- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: unit idle; a request is accepted when `req_valid_i` and `req_ready_o` are both high.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `req_unsigned_i` in 1: zero-extend load data.
- `req_addr_i` in ADDR_WIDTH: byte address.
- `req_wdata_i` in DATA_WIDTH: store data, right-aligned.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out DATA_WIDTH: extended load data; 0 for stores and errors.
- `rsp_cause_o` out 2: 0 = OK, 1 = MISALIGNED, 2 = BUS_ERR, 3 = TIMEOUT.
- Wishbone master: `dat_i` in DATA_WIDTH, `dat_o` out DATA_WIDTH, `ack_i`/`err_i`/`rty_i` in 1, `stb_o`/`cyc_o`/`we_o` out 1, `adr_o` out ADDR_WIDTH, `sel_o` out DATA_WIDTH/8.

## Operation
- **Reset values:** every output is 0, including `req_ready_o`. Once reset is released, state is IDLE and `req_ready_o` = 1.
- **States:**
  - IDLE: `req_ready_o` = 1. On accept, latch the request. A misaligned request goes to RESP; an aligned one goes to BUS.
  - BUS: `cyc_o` = `stb_o` = 1, all bus outputs stable. Termination priority is `err_i` > `ack_i` > `rty_i`.
    - `err_i` → RESP with BUS_ERR.
    - `ack_i` → capture `dat_i` if load → RESP with OK.
    - `rty_i` with retry count < MAX_RETRY → BACKOFF, count + 1.
    - `rty_i` with retry count = MAX_RETRY → RESP with BUS_ERR.
  - BACKOFF: one cycle with `cyc_o` = `stb_o` = 0, then BUS with identical outputs.
  - RESP: `rsp_valid_o` = 1 for exactly one cycle, then IDLE. There is no response back-pressure.
- **Misaligned:** the address is not a multiple of the access size, or the size is 3 with DATA_WIDTH = 32. No bus cycle is issued.
- **Lane math:** let `off` be the low log2(DATA_WIDTH/8) address bits.
  - `adr_o` = address with those bits cleared.
  - `sel_o` = (2^(2^size) − 1) << `off`.
  - `dat_o` = `req_wdata_i` << (8·`off`).
  - Load data = (`dat_i` >> 8·`off`) truncated to the access size, then sign-extended (or zero-extended if `req_unsigned_i`) to DATA_WIDTH.
- The retry counter and the watchdog counter clear on every accept.
- `req_*` inputs are ignored outside IDLE.
- An asynchronous reset mid-transaction immediately drops `cyc_o`/`stb_o` and discards the request. No response is issued.

## Timing
- All outputs are registered.
- **Zero-wait slave:** accept at cycle T → `stb_o` high at T+1 → `ack_i` at T+1 → `rsp_valid_o` at T+2 → `req_ready_o` at T+3.
- **Wait states:** k wait states add k cycles.
- **Retry:** each retry adds 2 cycles (BACKOFF plus re-issue).
- **Misaligned:** accept at T → `rsp_valid_o` at T+1.
- `ack_i`/`err_i`/`rty_i` are sampled only while `stb_o` is high; they are ignored in IDLE, BACKOFF and RESP.

## Configuration
- Macro `LSU_BUS_TIMEOUT_EN`.
- **Defined:** a watchdog counts BUS cycles since the last (re-)issue. After TIMEOUT_CYCLES cycles with no termination, the unit drops `cyc_o`/`stb_o` and goes to RESP with TIMEOUT. A termination in the same cycle as expiry wins over the timeout.
- **Undefined:** no counter is built, TIMEOUT_CYCLES is ignored, and BUS waits indefinitely. Cause 3 is never produced.

## Structure
- Shared package `lsu_pkg`: size encodings, cause codes, state encoding.
- Sub-module `lsu_lane_align`: combinational generation of `sel_o` and store data, load extraction and extension, and the misalignment flag, all parametrised by DATA_WIDTH.
- The top level holds the FSM, the retry and watchdog counters, and the output registers.

## Test plan
- **Aligned LW, 32-bit:** address 0x104, `dat_i` 0xDEADBEEF, ack after 2 waits → `adr_o` 0x104, `sel_o` 0xF, rdata 0xDEADBEEF, cause 0, `rsp_valid_o` at T+4.
- **LB signed/unsigned:** address 0x103, `dat_i` 0x80000000 → `sel_o` 0x8; signed rdata 0xFFFFFF80, unsigned rdata 0x00000080.
- **SH, DATA_WIDTH = 64:** address 0x16, wdata 0xABCD → `adr_o` 0x10, `sel_o` 0xC0, `dat_o` 0xABCD<<48, `we_o` 1.
- **Misaligned LW at 0x102:** → no `stb_o`, `rsp_valid_o` at T+1, cause 1.
- **Retry:** `rty_i` on 4 consecutive issues with MAX_RETRY = 3 → 4 `stb_o` pulses separated by one idle cycle, then cause 2. A variant that acks on the 3rd issue → cause 0.
- **Watchdog and reset:** with the macro and TIMEOUT_CYCLES = 8, no reply → cause 3 after 8 BUS cycles. Asserting `rst_i` mid-BUS → `cyc_o` = 0 immediately and no `rsp_valid_o`.
